// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and the MEM/WB register record for the memory/writeback stage.
package mem_wb_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Bit positions inside the 2-bit WB control field.
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Bit positions inside the 3-bit M control field, same packing as EX/MEM.
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic [1:0]        wb;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_W-1:0]  dst;
    } mem_wb_reg_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of EX/MEM outputs consumed by the stage and the IF / register-file results it produces.
// There is no valid/ready handshake: every signal is sampled or driven each cycle and the
// MEM/WB register advances on every rising edge outside reset.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic [1:0]        MEM_wb;
    logic              MEM_branch;
    logic              MEM_mem_read;
    logic              MEM_mem_write;
    logic [DATA_W-1:0] MEM_branch_target;
    logic              MEM_zero;
    logic [DATA_W-1:0] MEM_alu_result;
    logic [DATA_W-1:0] MEM_reg_data2;
    logic [REG_W-1:0]  MEM_reg_dst_mux_out;

    logic              MEM_pcsrc;
    logic [DATA_W-1:0] MEM_pc_target;
    logic [1:0]        WB_wb;
    logic [DATA_W-1:0] WB_read_data;
    logic [DATA_W-1:0] WB_alu_result;
    logic [REG_W-1:0]  WB_reg_dst_mux_out;
    logic              WB_reg_write;
    logic [DATA_W-1:0] WB_write_data;

    // Upstream side: drives the MEM-stage inputs, observes the results.
    modport master (
        output MEM_wb, MEM_branch, MEM_mem_read, MEM_mem_write, MEM_branch_target,
               MEM_zero, MEM_alu_result, MEM_reg_data2, MEM_reg_dst_mux_out,
        input  MEM_pcsrc, MEM_pc_target, WB_wb, WB_read_data, WB_alu_result,
               WB_reg_dst_mux_out, WB_reg_write, WB_write_data
    );

    // The stage itself.
    modport slave (
        input  MEM_wb, MEM_branch, MEM_mem_read, MEM_mem_write, MEM_branch_target,
               MEM_zero, MEM_alu_result, MEM_reg_data2, MEM_reg_dst_mux_out,
        output MEM_pcsrc, MEM_pc_target, WB_wb, WB_read_data, WB_alu_result,
               WB_reg_dst_mux_out, WB_reg_write, WB_write_data
    );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: asynchronous clear, synchronous write, combinational read.
module data_mem
    import mem_wb_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear every word on reset; otherwise commit a store at the rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read sees the pre-edge contents, giving read-before-write on a same-cycle store.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: data memory access, branch decision for IF,
// and the writeback mux / $0 guard feeding the register file.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               startin,
    mem_wb_stage_if.slave      bus
);

    logic [2:0]        mem_m;
    logic [ADDR_W-1:0] mem_idx;
    logic [DATA_W-1:0] mem_rdata;
    mem_wb_reg_t       wb_d;
    mem_wb_reg_t       wb_q;

    // Repack the M controls so field positions match the EX/MEM encoding.
    assign mem_m   = {bus.MEM_branch, bus.MEM_mem_read, bus.MEM_mem_write};
    // Byte-offset bits dropped; high bits ignored so the address wraps modulo DEPTH.
    assign mem_idx = bus.MEM_alu_result[ADDR_W+1:2];

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk_i   (clk),
        .rst_i   (startin),
        .we_i    (mem_m[M_MEMWRITE]),
        .addr_i  (mem_idx),
        .wdata_i (bus.MEM_reg_data2),
        .rdata_o (mem_rdata)
    );

    // Branch decision is purely combinational so IF can redirect in the same cycle.
    assign bus.MEM_pcsrc     = mem_m[M_BRANCH] & bus.MEM_zero;
    assign bus.MEM_pc_target = bus.MEM_branch_target;

    // Next MEM/WB contents; non-loads capture zero rather than whatever the array holds.
    always_comb begin
        wb_d            = '0;
        wb_d.wb         = bus.MEM_wb;
        wb_d.read_data  = mem_m[M_MEMREAD] ? mem_rdata : '0;
        wb_d.alu_result = bus.MEM_alu_result;
        wb_d.dst        = bus.MEM_reg_dst_mux_out;
    end

    // MEM/WB register: advances every edge, clears asynchronously.
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign bus.WB_wb              = wb_q.wb;
    assign bus.WB_read_data       = wb_q.read_data;
    assign bus.WB_alu_result      = wb_q.alu_result;
    assign bus.WB_reg_dst_mux_out = wb_q.dst;

    // Register $0 is hardwired, so never request a write to it.
    assign bus.WB_reg_write  = wb_q.wb[WB_REGWRITE] & (wb_q.dst != '0);
    assign bus.WB_write_data = wb_q.wb[WB_MEMTOREG] ? wb_q.read_data : wb_q.alu_result;

endmodule
